// File: rtl/spi_flash_bitstream_reader.sv
// Streams a byte range out of SPI configuration flash (READ 0x03, mode 0) onto a
// valid/ready byte port, holding SCK low whenever the one-byte output buffer is full.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start_i, CS high, SCK low
// S_CMD   | shifting 0x03 and the 24-bit address out on pico_o
// S_DATA  | clocking bytes in from poci_i, stalling SCK on back-pressure
// S_DRAIN | CS high, waiting for last handoff and CS idle time
// S_DONE  | one-cycle done_o pulse, then back to S_IDLE
module spi_flash_bitstream_reader #(
  parameter int CLK_DIV        = 2,
  parameter int CS_IDLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [23:0] start_addr_i,
  input  logic [23:0] length_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sck_o,
  output logic        cs_o,
  output logic        pico_o,
  input  logic        poci_i
);

  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  DIV_LOAD  = 8'(CLK_DIV - 1);
  localparam int          IDLE_C    = (CS_IDLE_CYCLES > 0) ? CS_IDLE_CYCLES - 1 : 0;
  localparam logic [15:0] IDLE_LOAD = 16'(IDLE_C);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sck_q, sck_d;
  logic        cs_q, cs_d;
  logic        pico_q, pico_d;
  logic [30:0] cmd_sr_q, cmd_sr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [23:0] byte_cnt_q, byte_cnt_d;
  logic [23:0] len_q, len_d;
  logic        pend_q, pend_d;
  logic        last_q, last_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [15:0] idle_q, idle_d;
  logic        tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      pico_q     <= 1'b0;
      cmd_sr_q   <= '0;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      pend_q     <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      pico_q     <= pico_d;
      cmd_sr_q   <= cmd_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      pend_q     <= pend_d;
      last_q     <= last_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      idle_q     <= idle_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    pico_d     = pico_q;
    cmd_sr_d   = cmd_sr_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    pend_d     = pend_q;
    last_d     = last_q;
    data_d     = data_q;
    valid_d    = valid_q;
    idle_d     = idle_q;
    tick       = (div_q == 8'd0);

    // A completed byte waits in rx_sr_q (pend_q) until the output register is free.
    if (pend_q && (!valid_q || ready_i)) begin
      data_d  = rx_sr_q;
      valid_d = 1'b1;
      pend_d  = 1'b0;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d      = length_i;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          last_d     = 1'b0;
          cmd_sr_d   = {CMD_READ[6:0], start_addr_i};
          div_d      = DIV_LOAD;
          if (length_i == 24'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CMD;
            cs_d    = 1'b0;
            pico_d  = CMD_READ[7];
          end
        end
      end
      S_CMD: begin
        if (!tick) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = DIV_LOAD;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_cnt_q == 5'd31) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
              pico_d    = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
              pico_d    = cmd_sr_q[30];
              cmd_sr_d  = {cmd_sr_q[29:0], 1'b0};
            end
          end
        end
      end
      S_DATA: begin
        if (!tick) begin
          div_d = div_q - 8'd1;
        end else if (sck_q) begin
          div_d = DIV_LOAD;
          sck_d = 1'b0;
          if (last_q) begin
            state_d = S_DRAIN;
            cs_d    = 1'b1;
            idle_d  = IDLE_LOAD;
          end
        end else if (!pend_q) begin
          // Rising edge only when the shift register is free; otherwise SCK holds low.
          div_d   = DIV_LOAD;
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[6:0], poci_i};
          if (bit_cnt_q[2:0] == 3'd7) begin
            bit_cnt_d  = '0;
            pend_d     = 1'b1;
            byte_cnt_d = byte_cnt_q + 24'd1;
            last_d     = ((byte_cnt_q + 24'd1) == len_q);
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      S_DRAIN: begin
        if (idle_q != 16'd0) begin
          idle_d = idle_q - 16'd1;
        end else if (!pend_q && !valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_DONE);
    data_o  = data_q;
    valid_o = valid_q;
    sck_o   = sck_q;
    cs_o    = cs_q;
    pico_o  = pico_q;
  end

endmodule

// File: tb/tb_spi_flash_bitstream_reader.sv
// Directed bench: flash model per DUT, table of plain reads plus hand sequences for
// back-pressure, reset mid-transaction, start while busy and CLK_DIV=1.
module tb_spi_flash_bitstream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] start, busy, done, valid, ready, sck, cs, pico, poci;
  logic [23:0] addr [2];
  logic [23:0] len [2];
  logic [7:0]  data [2];

  logic [7:0]  fl_mem [8];
  int          rises [2];
  logic [31:0] cmd_word [2];

  int cs_low [2], sck_hi [2], done_n [2], got_n [2], cs_hi_run [2], cs_hi_at_done [2];
  logic [7:0] got [2][256];

  int n_tests = 0;
  int n_fail  = 0;

  spi_flash_bitstream_reader #(.CLK_DIV(2), .CS_IDLE_CYCLES(4)) u_dut0 (
    .clk(clk), .reset(reset), .start_i(start[0]), .start_addr_i(addr[0]), .length_i(len[0]),
    .busy_o(busy[0]), .done_o(done[0]), .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready[0]),
    .sck_o(sck[0]), .cs_o(cs[0]), .pico_o(pico[0]), .poci_i(poci[0]));

  spi_flash_bitstream_reader #(.CLK_DIV(1), .CS_IDLE_CYCLES(4)) u_dut1 (
    .clk(clk), .reset(reset), .start_i(start[1]), .start_addr_i(addr[1]), .length_i(len[1]),
    .busy_o(busy[1]), .done_o(done[1]), .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready[1]),
    .sck_o(sck[1]), .cs_o(cs[1]), .pico_o(pico[1]), .poci_i(poci[1]));

  for (genvar g = 0; g < 2; g++) begin : g_env
    // Flash: capture command on SCK rises, present data bit before the next rise.
    always @(posedge sck[g] or posedge cs[g]) begin
      if (cs[g]) rises[g] = 0;
      else begin
        if (rises[g] < 32) cmd_word[g] = {cmd_word[g][30:0], pico[g]};
        rises[g] = rises[g] + 1;
      end
    end
    assign poci[g] = (rises[g] >= 32 && rises[g] < 96) ?
                     fl_mem[(rises[g] - 32) / 8][7 - ((rises[g] - 32) % 8)] : 1'b0;

    always @(negedge clk) begin
      if (done[g]) begin
        cs_hi_at_done[g] = cs_hi_run[g];
        done_n[g] = done_n[g] + 1;
      end
      if (cs[g]) cs_hi_run[g] = cs_hi_run[g] + 1;
      else begin
        cs_low[g] = cs_low[g] + 1;
        cs_hi_run[g] = 0;
      end
      if (sck[g]) sck_hi[g] = sck_hi[g] + 1;
      if (valid[g] && ready[g]) begin
        got[g][got_n[g] % 256] = data[g];
        got_n[g] = got_n[g] + 1;
      end
    end
  end

  typedef struct packed {
    logic [23:0] addr;
    logic [23:0] len;
    logic [31:0] bytes;
    logic [31:0] exp_cmd;
    logic [31:0] exp_cs_low;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_txn(input int g, input logic [23:0] a, input logic [23:0] l);
    @(posedge clk); #1;
    start[g] = 1'b1; addr[g] = a; len[g] = l;
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (done[g]) seen = 1;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_rises(input int g, input int n);
    bit seen = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge clk);
      if (rises[g] >= n) seen = 1;
    end
    check("rises_reached", 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, s0, g0, cyc;
    bit ok_data, ok_sck, seen;
    foreach (rises[i]) begin
      rises[i] = 0; cmd_word[i] = '0; cs_low[i] = 0; sck_hi[i] = 0; done_n[i] = 0;
      got_n[i] = 0; cs_hi_run[i] = 0; cs_hi_at_done[i] = 0; addr[i] = '0; len[i] = '0;
    end
    foreach (fl_mem[i]) fl_mem[i] = 8'h00;
    start = '0; ready = 2'b11; reset = 1'b1;

    vecs[0] = '{24'h100000, 24'd4, 32'hDEADBEEF, 32'h03100000, 32'd256};
    vecs[1] = '{24'hABCDEF, 24'd1, 32'h5A000000, 32'h03ABCDEF, 32'd160};
    vecs[2] = '{24'h000001, 24'd2, 32'h00FF0000, 32'h03000001, 32'd192};
    vecs[3] = '{24'h00FFFF, 24'd3, 32'h817E0100, 32'h0300FFFF, 32'd224};
    vecs[4] = '{24'h123456, 24'd0, 32'h00000000, 32'h00000000, 32'd0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs0", {cs[0], sck[0], pico[0], valid[0], data[0], busy[0], done[0]}, 32'h2000);
    check("reset_outs1", {cs[1], sck[1], pico[1], valid[1], data[1], busy[1], done[1]}, 32'h2000);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) fl_mem[j] = vecs[i].bytes[31 - 8 * j -: 8];
      c0 = cs_low[0]; d0 = done_n[0]; s0 = sck_hi[0]; g0 = got_n[0];
      start_txn(0, vecs[i].addr, vecs[i].len);
      wait_done(0, cyc);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_done_count", i), 32'(done_n[0] - d0), 32'd1);
      check($sformatf("v%0d_cs_low", i), 32'(cs_low[0] - c0), vecs[i].exp_cs_low);
      check($sformatf("v%0d_sck_high", i), 32'(sck_hi[0] - s0), vecs[i].exp_cs_low / 2);
      check($sformatf("v%0d_byte_count", i), 32'(got_n[0] - g0), 32'(vecs[i].len));
      for (int j = 0; j < int'(vecs[i].len); j++)
        check($sformatf("v%0d_byte%0d", i, j), 32'(got[0][(g0 + j) % 256]),
              32'(vecs[i].bytes[31 - 8 * j -: 8]));
      if (vecs[i].len != 24'd0) check($sformatf("v%0d_cmd", i), cmd_word[0], vecs[i].exp_cmd);
      else check($sformatf("v%0d_done_latency_le2", i), 32'(cyc <= 2), 32'd1);
    end

    // Back-pressure: sink stalls for 100 cycles after the first byte appears.
    fl_mem[0] = 8'hDE; fl_mem[1] = 8'hAD; fl_mem[2] = 8'hBE; fl_mem[3] = 8'hEF;
    ready[0] = 1'b0;
    g0 = got_n[0];
    start_txn(0, 24'h100000, 24'd4);
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (valid[0]) seen = 1;
    end
    check("bp_first_valid", 32'(seen), 32'd1);
    ok_data = 1; ok_sck = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (data[0] !== 8'hDE || valid[0] !== 1'b1) ok_data = 0;
      if (k >= 40 && sck[0] !== 1'b0) ok_sck = 0;
    end
    check("bp_data_held_DE", 32'(ok_data), 32'd1);
    check("bp_sck_frozen_low", 32'(ok_sck), 32'd1);
    check("bp_rises_at_stall", 32'(rises[0]), 32'd48);
    ready[0] = 1'b1;
    wait_done(0, cyc);
    repeat (3) @(negedge clk);
    check("bp_byte_count", 32'(got_n[0] - g0), 32'd4);
    for (int j = 0; j < 4; j++)
      check($sformatf("bp_byte%0d", j), 32'(got[0][(g0 + j) % 256]), 32'(fl_mem[j]));

    // Reset during the address phase, then a clean read.
    start_txn(0, 24'h345678, 24'd4);
    wait_rises(0, 12);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outs", {cs[0], sck[0], valid[0], busy[0]}, 32'b1000);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    fl_mem[0] = 8'h12; fl_mem[1] = 8'h34;
    g0 = got_n[0];
    start_txn(0, 24'h000010, 24'd2);
    wait_done(0, cyc);
    repeat (3) @(negedge clk);
    check("rst_after_cmd", cmd_word[0], 32'h03000010);
    check("rst_after_count", 32'(got_n[0] - g0), 32'd2);
    check("rst_after_b0", 32'(got[0][g0 % 256]), 32'h12);
    check("rst_after_b1", 32'(got[0][(g0 + 1) % 256]), 32'h34);

    // Start pulse during DATA must be ignored.
    fl_mem[0] = 8'h5A; fl_mem[1] = 8'hC3;
    c0 = cs_low[0]; d0 = done_n[0]; g0 = got_n[0];
    start_txn(0, 24'h000200, 24'd2);
    wait_rises(0, 36);
    start_txn(0, 24'hFFFFFF, 24'd1);
    wait_done(0, cyc);
    repeat (20) @(negedge clk);
    check("busy_start_done_count", 32'(done_n[0] - d0), 32'd1);
    check("busy_start_cs_low", 32'(cs_low[0] - c0), 32'd192);
    check("busy_start_cmd", cmd_word[0], 32'h03000200);
    check("busy_start_count", 32'(got_n[0] - g0), 32'd2);
    check("busy_start_b0", 32'(got[0][g0 % 256]), 32'h5A);
    check("busy_start_b1", 32'(got[0][(g0 + 1) % 256]), 32'hC3);

    // CLK_DIV=1, one byte.
    fl_mem[0] = 8'hA5;
    c0 = cs_low[1]; d0 = done_n[1]; s0 = sck_hi[1]; g0 = got_n[1];
    start_txn(1, 24'h000000, 24'd1);
    wait_done(1, cyc);
    repeat (3) @(negedge clk);
    check("div1_cmd", cmd_word[1], 32'h03000000);
    check("div1_cs_low", 32'(cs_low[1] - c0), 32'd80);
    check("div1_sck_high", 32'(sck_hi[1] - s0), 32'd40);
    check("div1_byte_count", 32'(got_n[1] - g0), 32'd1);
    check("div1_byte", 32'(got[1][g0 % 256]), 32'hA5);
    check("div1_done_count", 32'(done_n[1] - d0), 32'd1);
    check("div1_cs_idle_ge4", 32'(cs_hi_at_done[1] >= 4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_bitstream_reader.md
# spi_flash_bitstream_reader

Reads a FABulous bitstream out of the on-board SPI configuration flash and delivers it byte by byte to the fabric configuration path. It issues one standard READ (0x03) transaction per request and drives the flash pins `sck_o`, `cs_o` and `pico_o`, and samples `poci_i`, at the board top level. Output bytes leave through a valid/ready port that feeds the same configuration byte sink as the UART and USB DFU paths.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles; legal range 1..255.
- `CS_IDLE_CYCLES`, default 4: minimum number of `clk` cycles `cs_o` stays high after a transaction.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start_i` input 1: one-cycle request; sampled only in IDLE.
- `start_addr_i` input 24: flash byte address; captured on an accepted `start_i`.
- `length_i` input 24: number of bytes to read; captured on an accepted `start_i`.
- `busy_o` output 1: high from the accepted start until DONE is exited.
- `done_o` output 1: one-cycle pulse at the end of a transaction.
- `data_o` output 8: byte read from flash, MSB first on the wire.
- `valid_o` output 1: `data_o` holds a byte.
- `ready_i` input 1: the sink accepts the byte when `valid_o` and `ready_i` are both high.
- `sck_o` output 1: SPI clock, mode 0, idles low.
- `cs_o` output 1: flash chip select, active low.
- `pico_o` output 1: controller-to-flash data.
- `poci_i` input 1: flash-to-controller data.

## Operation
- Reset values: `cs_o`=1, `sck_o`=0, `pico_o`=0, `valid_o`=0, `data_o`=0, `busy_o`=0, `done_o`=0. State goes to IDLE. Reset has priority over every other event, including mid-transaction; the flash simply sees CS rise.
- **IDLE**
  - An accepted `start_i` captures the address and length and sets `busy_o`.
  - If `length_i` is 0, go to DONE; `cs_o` never falls.
  - Otherwise go to CMD and drive `cs_o` low.
  - `start_i` in any other state is ignored.
- **CMD**
  - Shift 32 bits MSB first: 0x03, then `start_addr_i[23:16]`, `[15:8]`, `[7:0]`.
  - Go to DATA after the 32nd falling edge.
- **DATA**
  - Clock 8 bits per byte.
  - `poci_i` is sampled on each SCK rising edge into an 8-bit shift register, MSB first.
  - `pico_o` is held at 0.
- **Byte handoff**
  - When the 8th bit is sampled and `valid_o` is 0, load `data_o` and set `valid_o` on the next `clk` edge.
  - If `valid_o` is still 1, SCK stops low before the next byte's first rise until the handshake completes; then load and resume. This gives one byte of buffering.
  - `valid_o` clears on the handshake unless a new byte loads in the same cycle; in that case it stays 1 with the new data.
- **Byte counter**
  - 24-bit, incremented per byte shifted in.
  - After byte `length` has been shifted in, go to DRAIN.
- **DRAIN**: raise `cs_o` and keep SCK low. Wait until the last byte is handed off and `CS_IDLE_CYCLES` have elapsed with `cs_o` high, then go to DONE.
- **DONE**: pulse `done_o` for one cycle, clear `busy_o`, return to IDLE.

## Timing
- **SCK**: each phase lasts `CLK_DIV` cycles, so one bit takes 2·`CLK_DIV` clk cycles.
- **Transaction start**:
  - `cs_o` falls on the edge after the accepted `start_i`, with `pico_o` = bit 31 already valid.
  - The first SCK rise occurs `CLK_DIV` cycles later.
- **`pico_o` timing**: it changes only on the `clk` edge that drives SCK low, or at CS fall for the first bit.
- **Sampling point**: `poci_i` is sampled on the same `clk` edge that drives SCK high.
- **Byte latency**: `valid_o` rises 1 clk after the 8th sample of a byte, when no stall is active.
- **Transaction length without back-pressure**: `cs_o` is low for (32 + 8·length)·2·`CLK_DIV` cycles.
- **End of transaction**: `cs_o` rises `CLK_DIV` cycles after the final SCK rise.
- **Back-to-back**: the earliest next accepted `start_i` is the cycle after `done_o`.

## Test plan
- **Basic read, no back-pressure**:
  - Stimulus: `CLK_DIV`=2, addr 0x100000, length 4, flash model returns DE AD BE EF, `ready_i` tied 1.
  - Required: the bench sees 0x03100000 on `pico_o`, then four bytes in order DE, AD, BE, EF.
  - Required: `cs_o` low exactly 256 cycles, then one `done_o` pulse.
- **Back-pressure**:
  - Stimulus: `ready_i`=0 for 100 cycles after the first `valid_o`.
  - Required: SCK is frozen low after byte 2 completes; `data_o` stays 0xDE throughout.
  - Required: after release, bytes arrive in order with no loss or duplication.
- **Zero length**:
  - Stimulus: `length_i`=0.
  - Required: `cs_o` stays 1 and `sck_o` never toggles.
  - Required: `done_o` pulses within 2 cycles of `start_i`.
- **Reset mid-transaction**:
  - Stimulus: assert `reset` during the address phase.
  - Required: next cycle `cs_o`=1, `sck_o`=0, `valid_o`=0, `busy_o`=0.
  - Required: a following start reads correctly.
- **Start while busy**:
  - Stimulus: pulse `start_i` with a different address during DATA.
  - Required: it is ignored; only the original transaction's bytes are produced and there is one `done_o`.
- **`CLK_DIV`=1, length 1**:
  - Stimulus: set `CLK_DIV`=1 and request one byte with the flash model returning 0xA5.
  - Required: SCK period is 2 cycles; 0xA5 delivered; `cs_o` stays high at least 4 cycles before `done_o`.
